// File: rtl/vu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : vu_pkg                                                      |
// | Purpose: Shared defaults and helpers for the multi-channel VU meter. |
// |          sat_abs() returns the magnitude of a sign-extended sample,  |
// |          clamped to full scale 2^(width-1)-1.                        |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package vu_pkg;

  localparam int unsigned C_DEF_CHANNELS     = 2;
  localparam int unsigned C_DEF_WIDTH        = 8;
  localparam int unsigned C_DEF_DECAY_DIV    = 96;
  localparam int unsigned C_DEF_HOLD_STROBES = 48000;

  // The most negative sample has no positive twin; it clamps to full scale.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] sample,
                                          input int unsigned         width);
    logic [31:0] fs;
    logic [31:0] mag;
    fs = (32'd1 << (width - 1)) - 32'd1;
    if (sample < 0) begin
      mag = 32'(-sample);
    end else begin
      mag = 32'(sample);
    end
    if (mag > fs) begin
      mag = fs;
    end
    return mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vu_meter_array_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : vu_meter_array_channel                                      |
// | Purpose: One VU meter channel: magnitude, envelope with instant      |
// |          attack and ticked linear decay, peak hold for the clip LED, |
// |          period-aligned duty latch and PWM compare.                  |
// | Ports  : clk, reset        clock / sync active-high reset            |
// |          strobe_i          audio sample strobe                       |
// |          audio_enable_i    0 forces magnitude to 0                   |
// |          decay_tick_i      shared envelope decay tick                |
// |          pwm_wrap_i        last cycle of the PWM period              |
// |          pwm_cnt_i         shared PWM counter                        |
// |          sample_i          signed audio sample                       |
// |          vu_pwm_o, clip_o  registered meter drive / clip indicator   |
// |          env_o             current envelope                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vu_meter_array_channel
  import vu_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int HOLD_STROBES = 48000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_i,
  input  logic             audio_enable_i,
  input  logic             decay_tick_i,
  input  logic             pwm_wrap_i,
  input  logic [WIDTH-2:0] pwm_cnt_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic             vu_pwm_o,
  output logic             clip_o,
  output logic [WIDTH-2:0] env_o
);

  localparam int LW = WIDTH - 1;
  localparam int HW = (HOLD_STROBES > 1) ? $clog2(HOLD_STROBES) : 1;
  localparam logic [LW-1:0] C_FS       = '1;
  localparam logic [HW-1:0] C_HOLD_MAX = HW'(HOLD_STROBES - 1);
  localparam logic [HW-1:0] C_HOLD_ONE = HW'(1);
  localparam logic [LW-1:0] C_ENV_ONE  = LW'(1);

  logic [31:0]   w_abs;
  logic [LW-1:0] w_mag;
  logic          w_unused_abs;

  logic [LW-1:0] env_q, env_d;
  logic [LW-1:0] peak_q, peak_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [LW-1:0] duty_q, duty_d;
  logic          vu_pwm_q;
  logic          clip_q;

  assign w_abs        = sat_abs({{(32-WIDTH){sample_i[WIDTH-1]}}, sample_i}, WIDTH);
  assign w_unused_abs = ^w_abs[31:LW];
  assign w_mag        = audio_enable_i ? w_abs[LW-1:0] : '0;

  always_comb begin
    env_d  = env_q;
    peak_d = peak_q;
    hold_d = hold_q;
    if (strobe_i) begin
      // Attack takes priority over a coincident decay tick.
      if (w_mag > env_q) begin
        env_d = w_mag;
      end else if (decay_tick_i && (env_q != '0)) begin
        env_d = env_q - C_ENV_ONE;
      end
      // Once the hold expires the peak tracks the freshly updated envelope.
      if (w_mag >= peak_q) begin
        peak_d = w_mag;
        hold_d = C_HOLD_MAX;
      end else if (hold_q != '0) begin
        hold_d = hold_q - C_HOLD_ONE;
      end else begin
        peak_d = env_d;
      end
    end
    // Duty only moves at the period boundary so a period is never split.
    duty_d = pwm_wrap_i ? env_q : duty_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      env_q    <= '0;
      peak_q   <= '0;
      hold_q   <= '0;
      duty_q   <= '0;
      vu_pwm_q <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      env_q    <= env_d;
      peak_q   <= peak_d;
      hold_q   <= hold_d;
      duty_q   <= duty_d;
      vu_pwm_q <= (pwm_cnt_i < duty_q);
      clip_q   <= (peak_q == C_FS);
    end
  end

  assign vu_pwm_o = vu_pwm_q;
  assign clip_o   = clip_q;
  assign env_o    = env_q;

endmodule
`default_nettype wire

// File: rtl/vu_meter_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : vu_meter_array                                              |
// | Purpose: Multi-channel VU meter driver. Holds the shared decay       |
// |          prescaler and PWM counter and one channel slice per input.  |
// | Ports  : clk, reset        clock / sync active-high reset            |
// |          audio_clk_enable  one-clk strobe per audio sample           |
// |          audio_enable      0 forces input magnitudes to 0            |
// |          audio_sample      packed signed samples, ch c at c*WIDTH    |
// |          vu_pwm            registered PWM meter drive per channel    |
// |          clip              registered clip indicator per channel     |
// |          test              [WIDTH-2:0] ch0 envelope, [15] decay tick |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module vu_meter_array
  import vu_pkg::*;
#(
  parameter int CHANNELS     = int'(C_DEF_CHANNELS),
  parameter int WIDTH        = int'(C_DEF_WIDTH),
  parameter int DECAY_DIV    = int'(C_DEF_DECAY_DIV),
  parameter int HOLD_STROBES = int'(C_DEF_HOLD_STROBES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      audio_clk_enable,
  input  logic                      audio_enable,
  input  logic [CHANNELS*WIDTH-1:0] audio_sample,
  output logic [CHANNELS-1:0]       vu_pwm,
  output logic [CHANNELS-1:0]       clip,
  output logic [15:0]               test
);

  localparam int LW = WIDTH - 1;
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] C_PRESC_MAX = DW'(DECAY_DIV - 1);
  localparam logic [DW-1:0] C_PRESC_ONE = DW'(1);
  localparam logic [LW-1:0] C_PWM_LAST  = {{(LW-1){1'b1}}, 1'b0};
  localparam logic [LW-1:0] C_PWM_ONE   = LW'(1);

  logic [DW-1:0] presc_q, presc_d;
  logic [LW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          w_decay_tick;
  logic          w_pwm_wrap;
  logic [LW-1:0] w_env [CHANNELS];
  logic [15:0]   w_test;

  assign w_decay_tick = audio_clk_enable && (presc_q == C_PRESC_MAX);
  // Counter runs 0..FS-1, giving a period of exactly FS clocks.
  assign w_pwm_wrap   = (pwm_cnt_q == C_PWM_LAST);

  always_comb begin
    presc_d = presc_q;
    if (audio_clk_enable) begin
      presc_d = w_decay_tick ? '0 : presc_q + C_PRESC_ONE;
    end
    pwm_cnt_d = w_pwm_wrap ? '0 : pwm_cnt_q + C_PWM_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    vu_meter_array_channel #(
      .WIDTH        (WIDTH),
      .HOLD_STROBES (HOLD_STROBES)
    ) u_channel (
      .clk            (clk),
      .reset          (reset),
      .strobe_i       (audio_clk_enable),
      .audio_enable_i (audio_enable),
      .decay_tick_i   (w_decay_tick),
      .pwm_wrap_i     (w_pwm_wrap),
      .pwm_cnt_i      (pwm_cnt_q),
      .sample_i       (audio_sample[c*WIDTH +: WIDTH]),
      .vu_pwm_o       (vu_pwm[c]),
      .clip_o         (clip[c]),
      .env_o          (w_env[c])
    );
  end

  always_comb begin
    w_test         = '0;
    w_test[LW-1:0] = w_env[0];
    w_test[15]     = w_decay_tick;
  end

  assign test = w_test;

endmodule
`default_nettype wire

// File: tb/tb_vu_meter_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_vu_meter_array                                           |
// | Purpose: Self-checking bench for vu_meter_array with a per-strobe    |
// |          behavioural model of envelope, peak hold and clip, and PWM  |
// |          duty measured as high cycles over one full period.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_vu_meter_array;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int H  = 8;
  localparam int FS = (1 << (W - 1)) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          audio_clk_enable;
  logic          audio_enable;
  logic [CH*W-1:0] audio_sample;
  logic [CH-1:0] vu_pwm;
  logic [CH-1:0] clip;
  logic [15:0]   test;

  int checks   = 0;
  int failures = 0;

  int            m_env  [CH];
  int            m_peak [CH];
  int            m_hold [CH];
  int            m_scnt;
  logic [CH-1:0] m_clip;

  always #5 clk = ~clk;

  vu_meter_array #(
    .CHANNELS     (CH),
    .WIDTH        (W),
    .DECAY_DIV    (D),
    .HOLD_STROBES (H)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .audio_clk_enable (audio_clk_enable),
    .audio_enable     (audio_enable),
    .audio_sample     (audio_sample),
    .vu_pwm           (vu_pwm),
    .clip             (clip),
    .test             (test)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mag_of(input logic [CH*W-1:0] smp, input int c, input logic en);
    logic [W-1:0] b;
    int v;
    b = smp[c*W +: W];
    v = int'($signed(b));
    if (!en) return 0;
    if (v < 0) v = -v;
    if (v > FS) v = FS;
    return v;
  endfunction

  function automatic logic [CH*W-1:0] one_ch(input logic [W-1:0] v);
    logic [CH*W-1:0] r;
    r        = '0;
    r[W-1:0] = v;
    return r;
  endfunction

  function automatic logic [CH*W-1:0] rand_smp();
    logic [CH*W-1:0] r;
    int k;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      r[c*W +: W] = 8'h80;
      else if (k == 1) r[c*W +: W] = 8'h7F;
      else if (k == 2) r[c*W +: W] = '0;
      else             r[c*W +: W] = W'($urandom);
    end
    return r;
  endfunction

  // One clock: drive at negedge, advance the model at posedge, compare after.
  task automatic cyc(input logic s, input logic en, input logic rst, input logic [CH*W-1:0] smp);
    logic tick;
    int   mag;
    @(negedge clk);
    reset            = rst;
    audio_clk_enable = s;
    audio_enable     = en;
    audio_sample     = smp;
    tick = s && ((m_scnt % D) == D - 1);
    #1;
    if (!rst) check("decay_tick", 32'(test[15]), 32'(tick));
    @(posedge clk);
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_env[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
      end
      m_scnt = 0;
      m_clip = '0;
    end else begin
      for (int c = 0; c < CH; c++) m_clip[c] = (m_peak[c] == FS);
      if (s) begin
        for (int c = 0; c < CH; c++) begin
          mag = mag_of(smp, c, en);
          if (mag > m_env[c])                 m_env[c] = mag;
          else if (tick && m_env[c] > 0)      m_env[c] = m_env[c] - 1;
          if (mag >= m_peak[c]) begin
            m_peak[c] = mag;
            m_hold[c] = H - 1;
          end else if (m_hold[c] > 0) begin
            m_hold[c] = m_hold[c] - 1;
          end else begin
            m_peak[c] = m_env[c];
          end
        end
        m_scnt++;
      end
    end
    #1;
    check("env0", 32'(test[W-2:0]), m_env[0]);
    check("test_zero_bits", 32'(test[14:W-1]), 32'd0);
    check("clip", 32'(clip), 32'(m_clip));
    if (rst) begin
      check("pwm_in_reset", 32'(vu_pwm), 32'd0);
      if (!s) check("test_in_reset", 32'(test), 32'd0);
    end
  endtask

  // Let duty settle for two periods, then count high cycles over one period.
  task automatic measure(input string tag);
    int hi [CH];
    repeat (2 * FS + 4) cyc(1'b0, 1'b1, 1'b0, '0);
    for (int c = 0; c < CH; c++) hi[c] = 0;
    repeat (FS) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c < CH; c++) if (vu_pwm[c]) hi[c]++;
    end
    for (int c = 0; c < CH; c++) check(tag, hi[c], m_env[c]);
  endtask

  initial begin
    reset            = 1'b1;
    audio_clk_enable = 1'b0;
    audio_enable     = 1'b1;
    audio_sample     = '0;
    m_scnt           = 0;
    m_clip           = '0;
    for (int c = 0; c < CH; c++) begin
      m_env[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
    end

    repeat (3) cyc(1'b0, 1'b1, 1'b1, '0);
    repeat (10) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      check("idle_pwm", 32'(vu_pwm), 32'd0);
    end

    // Attack on channel 0 only.
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'd64));
    check("attack_env", 32'(test[W-2:0]), 32'd64);
    measure("attack_duty");

    // Reset in the middle of an active PWM period.
    repeat (40) cyc(1'b0, 1'b1, 1'b0, '0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1, '0);
    measure("post_reset_duty");

    // Most negative sample saturates to full scale and lights clip.
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'h80));
    check("sat_env", 32'(test[W-2:0]), FS);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("clip_set", 32'(clip[0]), 32'd1);
    measure("sat_duty");
    repeat (8) cyc(1'b1, 1'b1, 1'b0, '0);
    check("clip_held_8", 32'(clip[0]), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check("clip_dropped", 32'(clip[0]), 32'd0);

    // Linear decay from 10 with the audio gate closed.
    cyc(1'b0, 1'b1, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'd10));
    repeat (40) cyc(1'b1, 1'b0, 1'b0, rand_smp());
    check("decay_to_zero", 32'(test[W-2:0]), 32'd0);
    repeat (8) cyc(1'b1, 1'b0, 1'b0, rand_smp());
    check("decay_saturates", 32'(test[W-2:0]), 32'd0);
    measure("decay_duty");

    // Attack beats a coincident decay tick.
    cyc(1'b0, 1'b1, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'd3));
    repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'd5));
    check("tick_attack", 32'(test[W-2:0]), 32'd5);
    cyc(1'b0, 1'b1, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'd3));
    repeat (2) cyc(1'b1, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 1'b0, one_ch(8'd2));
    check("tick_decay", 32'(test[W-2:0]), 32'd2);

    // Randomised traffic, including sustained strobes and sporadic resets.
    repeat (8) begin
      repeat (150) begin
        cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 199) == 0), rand_smp());
      end
      measure("rand_duty");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
